// File: rtl/mux8_rr_arbiter_if.sv
// Bundle of request/data inputs and grant/forwarded-data outputs shared
// between the eight requesters, the downstream sink and the arbiter.
interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] din;
    logic       out_ready;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    logic       out_valid;
    logic       busy;

    // Requester/sink side drives requests, data and ready.
    modport master (
        output req, din, out_ready,
        input  gnt, sel, y, out_valid, busy
    );

    // Arbiter side.
    modport slave (
        input  req, din, out_ready,
        output gnt, sel, y, out_valid, busy
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter steering an 8:1 one-bit mux onto a valid/ready sink,
// with each grant capped at MAX_BURST transfers.
module mux8_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mux8_rr_arbiter_if.slave      bus,
    output logic                  dbg_state,
    output logic [2:0]            dbg_ptr,
    output logic [3:0]            dbg_cnt
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

    state_t     state, state_n;
    logic [7:0] gnt, gnt_n;
    logic [2:0] sel, sel_n;
    logic [2:0] ptr, ptr_n;
    logic [3:0] cnt, cnt_n;

    logic       out_valid;
    logic       xfer;
    logic       release_now;
    logic [2:0] start;
    logic [3:0] pick_res;

    // Returns {found, index} of the first set bit at or after start, mod 8.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] s);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = s + 3'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Handshake: a transfer happens on an edge where out_valid && out_ready;
    // out_valid depends only on state and req[sel], never on out_ready.
    assign out_valid   = (state == GRANT) && bus.req[sel];
    assign xfer        = out_valid && bus.out_ready;
    assign release_now = (state == GRANT) && (!bus.req[sel] || (xfer && cnt == LAST));
    assign start       = release_now ? sel + 3'd1 : ptr;
    assign pick_res    = pick(bus.req, start);

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (pick_res[3]) begin
                    sel_n   = pick_res[2:0];
                    gnt_n   = 8'b1 << pick_res[2:0];
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_n = sel + 3'd1;
                    if (pick_res[3]) begin
                        sel_n = pick_res[2:0];
                        gnt_n = 8'b1 << pick_res[2:0];
                        cnt_n = '0;
                    end else begin
                        gnt_n   = '0;
                        state_n = IDLE;
                    end
                end else if (xfer) begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.sel       = sel;
    assign bus.out_valid = out_valid;
    assign bus.y         = out_valid & bus.din[sel];
    assign bus.busy      = (state == GRANT);

    assign dbg_state = state;
    assign dbg_ptr   = ptr;
    assign dbg_cnt   = cnt;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: one instance with MAX_BURST=4 for the
// main scenarios, a second with MAX_BURST=2 for the round-robin sequence.
module tb_mux8_rr_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux8_rr_arbiter_if bus_a ();
    mux8_rr_arbiter_if bus_b ();

    logic       st_a, st_b;
    logic [2:0] ptr_a, ptr_b;
    logic [3:0] cnt_a, cnt_b;

    mux8_rr_arbiter #(.MAX_BURST(4)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .dbg_state(st_a), .dbg_ptr(ptr_a), .dbg_cnt(cnt_a)
    );

    mux8_rr_arbiter #(.MAX_BURST(2)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .dbg_state(st_b), .dbg_ptr(ptr_b), .dbg_cnt(cnt_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_a.req = '0; bus_a.din = '0; bus_a.out_ready = 1'b0;
        bus_b.req = '0; bus_b.din = '0; bus_b.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_gnt", bus_a.gnt, 8'h00);
        chk("idle_busy", {7'b0, bus_a.busy}, 8'h00);

        // Reset asserted mid-grant
        bus_a.req = 8'hFF;
        tick();
        chk("pre_rst_gnt", bus_a.gnt, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("rst_gnt", bus_a.gnt, 8'h00);
        chk("rst_sel", {5'b0, bus_a.sel}, 8'h00);
        chk("rst_busy", {7'b0, bus_a.busy}, 8'h00);
        chk("rst_y", {7'b0, bus_a.y}, 8'h00);
        chk("rst_valid", {7'b0, bus_a.out_valid}, 8'h00);
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", bus_a.gnt, 8'h01);
        chk("post_rst_sel", {5'b0, bus_a.sel}, 8'h00);

        // Requester 0 drops: back to idle with ptr = 1
        bus_a.req = 8'h00;
        tick();
        chk("drop0_busy", {7'b0, bus_a.busy}, 8'h00);
        chk("drop0_ptr", {5'b0, ptr_a}, 8'h01);

        // Single requester 5, burst limit 4, immediate regrant
        bus_a.req = 8'h20; bus_a.din = 8'h20; bus_a.out_ready = 1'b1;
        tick();
        chk("r5_gnt", bus_a.gnt, 8'h20);
        chk("r5_sel", {5'b0, bus_a.sel}, 8'h05);
        chk("r5_y", {7'b0, bus_a.y}, 8'h01);
        chk("r5_cnt0", {4'b0, cnt_a}, 8'h00);
        bus_a.din = 8'hDF;
        #1;
        chk("r5_y_zero", {7'b0, bus_a.y}, 8'h00);
        bus_a.din = 8'h20;
        tick(); chk("r5_cnt1", {4'b0, cnt_a}, 8'h01);
        tick(); chk("r5_cnt2", {4'b0, cnt_a}, 8'h02);
        tick(); chk("r5_cnt3", {4'b0, cnt_a}, 8'h03);
        tick();
        chk("r5_regrant_cnt", {4'b0, cnt_a}, 8'h00);
        chk("r5_regrant_gnt", bus_a.gnt, 8'h20);
        chk("r5_regrant_busy", {7'b0, bus_a.busy}, 8'h01);
        chk("r5_ptr", {5'b0, ptr_a}, 8'h06);

        // Hand over to requester 3 and apply backpressure
        bus_a.req = 8'h08; bus_a.out_ready = 1'b0;
        #1;
        chk("r5_drop_valid", {7'b0, bus_a.out_valid}, 8'h00);
        tick();
        chk("r3_gnt", bus_a.gnt, 8'h08);
        chk("r3_sel", {5'b0, bus_a.sel}, 8'h03);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_gnt", bus_a.gnt, 8'h08);
            chk("bp_cnt", {4'b0, cnt_a}, 8'h00);
            chk("bp_valid", {7'b0, bus_a.out_valid}, 8'h01);
        end
        bus_a.out_ready = 1'b1;
        tick(); chk("bp_resume1", {4'b0, cnt_a}, 8'h01);
        tick(); chk("bp_resume2", {4'b0, cnt_a}, 8'h02);

        // Early drop: requester 2 after one transfer, requester 6 waiting
        bus_a.req = 8'h04;
        tick();
        chk("r2_gnt", bus_a.gnt, 8'h04);
        chk("r2_ptr", {5'b0, ptr_a}, 8'h04);
        bus_a.req = 8'h44;
        tick();
        chk("r2_cnt1", {4'b0, cnt_a}, 8'h01);
        chk("r2_gnt_hold", bus_a.gnt, 8'h04);
        bus_a.req = 8'h40;
        #1;
        chk("r2_drop_valid", {7'b0, bus_a.out_valid}, 8'h00);
        tick();
        chk("r6_gnt", bus_a.gnt, 8'h40);
        chk("r6_sel", {5'b0, bus_a.sel}, 8'h06);
        chk("r6_cnt", {4'b0, cnt_a}, 8'h00);

        // Idle return from requester 6
        bus_a.req = 8'h00;
        tick();
        chk("idle_busy2", {7'b0, bus_a.busy}, 8'h00);
        chk("idle_gnt2", bus_a.gnt, 8'h00);
        chk("idle_y2", {7'b0, bus_a.y}, 8'h00);
        chk("idle_ptr2", {5'b0, ptr_a}, 8'h07);
        chk("idle_sel_hold", {5'b0, bus_a.sel}, 8'h06);

        // Round-robin fairness, MAX_BURST=2, req 0 and 7
        bus_b.req = 8'h81; bus_b.out_ready = 1'b1; bus_b.din = 8'h80;
        tick(); chk("rr_1", bus_b.gnt, 8'h01);
        tick(); chk("rr_2", bus_b.gnt, 8'h01);
        tick(); chk("rr_3", bus_b.gnt, 8'h80);
        chk("rr_3_y", {7'b0, bus_b.y}, 8'h01);
        tick(); chk("rr_4", bus_b.gnt, 8'h80);
        tick(); chk("rr_5", bus_b.gnt, 8'h01);
        chk("rr_ptr_wrap", {5'b0, ptr_b}, 8'h00);
        tick(); chk("rr_6", bus_b.gnt, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
